// File: rtl/fpga_bitstream_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the bitstream loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  localparam int BYTE_W = 8;
  localparam int BIDX_W = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_FETCH = 2'd1,
    LD_SHIFT = 2'd2
  } ld_state_e;

  // Bits to shift out of the next byte: a full byte, or whatever is left.
  function automatic logic [3:0] chunk_bits(input logic [31:0] remaining);
    return (remaining >= 32'(BYTE_W)) ? 4'(BYTE_W) : remaining[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_bitstream_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_bitstream_loader_if
//  Description : Host-side byte streams, start/busy/done of the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpga_bitstream_loader_if;
  import loader_pkg::*;

  logic              start;
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;
  logic              busy;
  logic              done;

  // Host side: feeds the bitstream, drains readback.
  modport master (
    output start, in_data, in_valid, rb_ready,
    input  in_ready, rb_data, rb_valid, busy, done
  );

  // Loader side.
  modport slave (
    input  start, in_data, in_valid, rb_ready,
    output in_ready, rb_data, rb_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/fpga_bitstream_loader_serdes.sv
`default_nettype none
// ============================================================================
//  Module      : prog_serdes
//  Description : Byte PISO driving the chain input and byte SIPO capturing
//                the chain tail, indexed by the loader's bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_serdes
  import loader_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load_i,
  input  wire logic              shift_i,
  input  wire logic [BIDX_W-1:0] bit_idx_i,
  input  wire logic [BYTE_W-1:0] par_i,
  output logic                   ser_o,
  input  wire logic              ser_i,
  output logic [BYTE_W-1:0]      cap_o
);

  logic [BYTE_W-1:0] sreg_q;
  logic [BYTE_W-1:0] rbreg_q;

  assign ser_o = sreg_q[0];

  // Capture view including the bit arriving this cycle, so the byte is
  // complete on the same edge that shifts its last bit.
  always_comb begin
    cap_o            = rbreg_q;
    cap_o[bit_idx_i] = ser_i;
  end

  // Load a fresh byte (clearing capture so unused upper bits read 0), or shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q  <= '0;
      rbreg_q <= '0;
    end else if (load_i) begin
      sreg_q  <= par_i;
      rbreg_q <= '0;
    end else if (shift_i) begin
      sreg_q  <= {1'b0, sreg_q[BYTE_W-1:1]};
      rbreg_q <= cap_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpga_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_bitstream_loader
//  Description : Serial configuration master: shifts CHAIN_LEN bits from a
//                byte stream into the prog chain and returns the displaced
//                chain contents as a readback byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpga_bitstream_loader
  import loader_pkg::*;
#(
  parameter int CHAIN_LEN = 128,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  fpga_bitstream_loader_if.slave host,
  output logic                  prog_en,
  output logic                  prog_in,
  input  wire logic             prog_out
);

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  sent_q;
  logic [3:0]        nbits_q;
  logic [BIDX_W-1:0] bidx_q;
  logic [BYTE_W-1:0] rb_data_q;
  logic              rb_valid_q;
  logic              done_q;

  logic              w_start_acc;
  logic              w_accept;
  logic              w_shift;
  logic              w_in_ready;
  logic              w_last;
  logic              w_final;
  logic              w_ser;
  logic [BYTE_W-1:0] w_cap;
  logic [31:0]       w_rem;

  assign w_rem   = 32'(CHAIN_LEN) - 32'(sent_q);
  assign w_last  = ({1'b0, bidx_q} == (nbits_q - 4'd1));
  assign w_final = ((32'(sent_q) + 32'd1) == 32'(CHAIN_LEN));

  // Next state and handshake strobes.
  always_comb begin
    state_d     = state_q;
    w_start_acc = 1'b0;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_in_ready  = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (host.start) begin
          w_start_acc = 1'b1;
          state_d     = LD_FETCH;
        end
      end
      LD_FETCH: begin
        // Only take a byte when its readback will have somewhere to go.
        w_in_ready = !(rb_valid_q && !host.rb_ready);
        if (w_in_ready && host.in_valid) begin
          w_accept = 1'b1;
          state_d  = LD_SHIFT;
        end
      end
      LD_SHIFT: begin
        w_shift = 1'b1;
        if (w_last) state_d = w_final ? LD_IDLE : LD_FETCH;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LD_IDLE;
    else        state_q <= state_d;
  end

  // Chain bit counter and per-byte bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q  <= '0;
      nbits_q <= '0;
      bidx_q  <= '0;
    end else begin
      if (w_start_acc)  sent_q <= '0;
      else if (w_shift) sent_q <= sent_q + CNT_W'(1);
      if (w_accept) begin
        nbits_q <= chunk_bits(w_rem);
        bidx_q  <= '0;
      end else if (w_shift) begin
        bidx_q  <= bidx_q + BIDX_W'(1);
      end
    end
  end

  // Readback holding register and sticky completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (w_shift && w_last) begin
        rb_data_q  <= w_cap;
        rb_valid_q <= 1'b1;
      end else if (rb_valid_q && host.rb_ready) begin
        rb_valid_q <= 1'b0;
      end
      if (w_start_acc)                     done_q <= 1'b0;
      else if (w_shift && w_last && w_final) done_q <= 1'b1;
    end
  end

  prog_serdes u_serdes (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (w_accept),
    .shift_i   (w_shift),
    .bit_idx_i (bidx_q),
    .par_i     (host.in_data),
    .ser_o     (w_ser),
    .ser_i     (prog_out),
    .cap_o     (w_cap)
  );

  assign prog_en       = w_shift;
  assign prog_in       = w_shift & w_ser;
  assign host.in_ready = w_in_ready;
  assign host.rb_data  = rb_data_q;
  assign host.rb_valid = rb_valid_q;
  assign host.busy     = (state_q != LD_IDLE);
  assign host.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpga_bitstream_loader
//  Description : Directed bench for the loader with 16-bit and 12-bit chain
//                models driving prog_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_bitstream_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic prog_en_a, prog_in_a, prog_out_a;
  logic prog_en_b, prog_in_b, prog_out_b;
  logic [15:0] chain_a = '0;
  logic [11:0] chain_b = '0;

  assign prog_out_a = chain_a[0];
  assign prog_out_b = chain_b[0];

  fpga_bitstream_loader_if ifa ();
  fpga_bitstream_loader_if ifb ();

  fpga_bitstream_loader #(.CHAIN_LEN(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .host(ifa),
    .prog_en(prog_en_a), .prog_in(prog_in_a), .prog_out(prog_out_a)
  );

  fpga_bitstream_loader #(.CHAIN_LEN(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .host(ifb),
    .prog_en(prog_en_b), .prog_in(prog_in_b), .prog_out(prog_out_b)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         en_a = 0, en_b = 0;
  int         done_rise_a = 0, done_rise_b = 0;
  logic       done_prev_a = 1'b0, done_prev_b = 1'b0;
  bit         bits_a[$];
  bit         bits_b[$];
  logic [7:0] rbq_a[$];
  logic [7:0] rbq_b[$];
  int         passed = 0, total = 0;
  int         t0 = 0;

  // Chain models, prog_in recorders, readback collectors, done-rise timestamps.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (prog_en_a) begin
      en_a    <= en_a + 1;
      chain_a <= {prog_in_a, chain_a[15:1]};
      bits_a.push_back(prog_in_a);
    end
    if (prog_en_b) begin
      en_b    <= en_b + 1;
      chain_b <= {prog_in_b, chain_b[11:1]};
      bits_b.push_back(prog_in_b);
    end
    if (ifa.rb_valid && ifa.rb_ready) rbq_a.push_back(ifa.rb_data);
    if (ifb.rb_valid && ifb.rb_ready) rbq_b.push_back(ifb.rb_data);
    if (ifa.done && !done_prev_a) done_rise_a <= cyc;
    if (ifb.done && !done_prev_b) done_rise_b <= cyc;
    done_prev_a <= ifa.done;
    done_prev_b <= ifb.done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] outs(input int sel);
    if (sel == 0)
      return {ifa.in_ready, ifa.rb_valid, ifa.busy, ifa.done, prog_en_a, prog_in_a, ifa.rb_data};
    return {ifb.in_ready, ifb.rb_valid, ifb.busy, ifb.done, prog_en_b, prog_in_b, ifb.rb_data};
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ifa.in_ready : ifb.in_ready;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? ifa.busy : ifb.busy;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 0) ? ifa.done : ifb.done;
  endfunction
  function automatic int en_of(input int sel);
    return (sel == 0) ? en_a : en_b;
  endfunction
  function automatic int rb_size(input int sel);
    return (sel == 0) ? rbq_a.size() : rbq_b.size();
  endfunction
  function automatic int bits_size(input int sel);
    return (sel == 0) ? bits_a.size() : bits_b.size();
  endfunction
  function automatic logic [7:0] rb_at(input int sel, input int idx);
    if (idx >= rb_size(sel)) return 8'hxx;
    return (sel == 0) ? rbq_a[idx] : rbq_b[idx];
  endfunction
  function automatic logic [15:0] bits_word(input int sel, input int base, input int n);
    logic [15:0] w = '0;
    for (int i = 0; i < n; i++)
      if (base + i < bits_size(sel)) w[i] = (sel == 0) ? bits_a[base+i] : bits_b[base+i];
    return w;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin ifa.in_valid = v; ifa.in_data = d; end
    else          begin ifb.in_valid = v; ifb.in_data = d; end
  endtask
  task automatic set_start(input int sel, input logic v);
    if (sel == 0) ifa.start = v; else ifb.start = v;
  endtask
  task automatic set_rbr(input int sel, input logic v);
    if (sel == 0) ifa.rb_ready = v; else ifb.rb_ready = v;
  endtask

  task automatic start_pulse(input int sel, input string tag);
    t0 = cyc;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    check({tag, "_busy_after_start"}, 32'(busy_of(sel)), 32'd1);
    check({tag, "_done_after_start"}, 32'(done_of(sel)), 32'd0);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] d, input string tag);
    bit ok = 1'b0;
    set_in(sel, 1'b1, d);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy(sel)) begin ok = 1'b1; break; end
    end
    check({tag, "_accept"}, 32'(ok), 32'd1);
    tick();
    set_in(sel, 1'b0, d);
  endtask

  task automatic wait_done(input int sel, input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (done_of(sel)) begin ok = 1'b1; break; end
      tick();
    end
    check({tag, "_done_reached"}, 32'(ok), 32'd1);
  endtask

  task automatic check_load(input int sel, input string tag, input int bb, input int eb,
                            input int rbb, input logic [15:0] exp_bits, input int exp_en,
                            input logic [7:0] rb0, input logic [7:0] rb1, input int exp_cyc);
    bit ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (rb_size(sel) >= rbb + 2) begin ok = 1'b1; break; end
      tick();
    end
    check({tag, "_rb_arrive"}, 32'(ok), 32'd1);
    check({tag, "_en_cycles"}, 32'(en_of(sel) - eb), 32'(exp_en));
    check({tag, "_prog_in_bits"}, 32'(bits_word(sel, bb, exp_en)), 32'(exp_bits));
    check({tag, "_rb0"}, 32'(rb_at(sel, rbb)), 32'(rb0));
    check({tag, "_rb1"}, 32'(rb_at(sel, rbb + 1)), 32'(rb1));
    if (exp_cyc != 0)
      check({tag, "_done_cycle"}, 32'(done_rise_a * (sel == 0 ? 1 : 0) + done_rise_b * (sel == 0 ? 0 : 1) - t0), 32'(exp_cyc));
    check({tag, "_busy_end"}, 32'(busy_of(sel)), 32'd0);
    check({tag, "_done_end"}, 32'(done_of(sel)), 32'd1);
  endtask

  task automatic run_load(input int sel, input logic [7:0] b0, input logic [7:0] b1, input string tag);
    start_pulse(sel, tag);
    send_byte(sel, b0, tag);
    send_byte(sel, b1, tag);
    wait_done(sel, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bb, eb, rbb, e0;
    bit ok;
    ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.rb_ready = 1'b1;
    ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.rb_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset_outs_a", 32'(outs(0)), 32'd0);
    check("reset_outs_b", 32'(outs(1)), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // First load into a zeroed 16-bit chain
    bb = bits_a.size(); eb = en_a; rbb = rbq_a.size();
    run_load(0, 8'hA5, 8'h3C, "t1");
    check_load(0, "t1", bb, eb, rbb, 16'h3CA5, 16, 8'h00, 8'h00, 19);
    check("t1_chain", 32'(chain_a), 32'h3CA5);

    // Reload zeros: readback returns the previous stream
    bb = bits_a.size(); eb = en_a; rbb = rbq_a.size();
    run_load(0, 8'h00, 8'h00, "t2");
    check_load(0, "t2", bb, eb, rbb, 16'h0000, 16, 8'hA5, 8'h3C, 19);
    check("t2_chain", 32'(chain_a), 32'h0000);

    // 12-bit chain: partial last byte
    bb = bits_b.size(); eb = en_b; rbb = rbq_b.size();
    run_load(1, 8'hFF, 8'hFF, "t3a");
    check_load(1, "t3a", bb, eb, rbb, 16'h0FFF, 12, 8'h00, 8'h00, 15);
    check("t3a_chain", 32'(chain_b), 32'h0FFF);
    bb = bits_b.size(); eb = en_b; rbb = rbq_b.size();
    run_load(1, 8'h00, 8'hF0, "t3b");
    check_load(1, "t3b", bb, eb, rbb, 16'h0000, 12, 8'hFF, 8'h0F, 15);
    check("t3b_chain", 32'(chain_b), 32'h0000);

    // Readback back-pressure stalls the chain
    bb = bits_a.size(); eb = en_a; rbb = rbq_a.size();
    set_rbr(0, 1'b0);
    start_pulse(0, "t4");
    send_byte(0, 8'h5A, "t4");
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (ifa.rb_valid) begin ok = 1'b1; break; end
      tick();
    end
    check("t4_rb_valid_rise", 32'(ok), 32'd1);
    set_in(0, 1'b1, 8'hC3);
    repeat (6) tick();
    check("t4_stall_en_cycles", 32'(en_a - eb), 32'd8);
    check("t4_stall_in_ready", 32'(ifa.in_ready), 32'd0);
    check("t4_stall_prog_en", 32'(prog_en_a), 32'd0);
    check("t4_stall_rb_valid", 32'(ifa.rb_valid), 32'd1);
    check("t4_stall_rb_data", 32'(ifa.rb_data), 32'h00);
    set_rbr(0, 1'b1);
    send_byte(0, 8'hC3, "t4");
    wait_done(0, "t4");
    check_load(0, "t4", bb, eb, rbb, 16'hC35A, 16, 8'h00, 8'h00, 0);
    check("t4_chain", 32'(chain_a), 32'hC35A);

    // Input gap with a stray start pulse
    bb = bits_a.size(); eb = en_a; rbb = rbq_a.size();
    start_pulse(0, "t5");
    send_byte(0, 8'h96, "t5");
    repeat (8) tick();
    e0 = en_a;
    tick();
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    repeat (3) tick();
    check("t5_gap_en_cycles", 32'(en_a - e0), 32'd0);
    check("t5_gap_busy", 32'(ifa.busy), 32'd1);
    check("t5_gap_done", 32'(ifa.done), 32'd0);
    send_byte(0, 8'h0F, "t5");
    wait_done(0, "t5");
    check_load(0, "t5", bb, eb, rbb, 16'h0F96, 16, 8'h5A, 8'hC3, 24);
    check("t5_chain", 32'(chain_a), 32'h0F96);

    // Asynchronous reset on the 4th shift cycle, then a clean reload
    eb = en_a;
    start_pulse(0, "t6");
    send_byte(0, 8'h11, "t6");
    set_in(0, 1'b1, 8'h22);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_reset_outs", 32'(outs(0)), 32'd0);
    check("t6_reset_en_cycles", 32'(en_a - eb), 32'd3);
    check("t6_reset_chain", 32'(chain_a), 32'h21F2);
    set_in(0, 1'b0, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    bb = bits_a.size(); eb = en_a; rbb = rbq_a.size();
    run_load(0, 8'hA5, 8'h3C, "t6r");
    check_load(0, "t6r", bb, eb, rbb, 16'h3CA5, 16, 8'hF2, 8'h21, 19);
    check("t6r_chain", 32'(chain_a), 32'h3CA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
